// File: rtl/softmax_stream_ctrl.sv
// softmax_stream_ctrl: serial N x N loader, mat_softmax initiator, row-major drainer.
// Optional WAIT timeout abort is built when SOFTMAX_STREAM_TIMEOUT_EN is defined.
module softmax_stream_ctrl #(
  parameter int N              = 4,
  parameter int WIDTH          = 32,
  parameter int FBITS          = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic signed [WIDTH-1:0]        in_data,
  output logic                           sm_start,
  output logic [N-1:0][N-1:0][WIDTH-1:0] sm_in,
  input  logic [N-1:0][N-1:0][WIDTH-1:0] sm_out,
  input  logic                           sm_done,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic signed [WIDTH-1:0]        out_data,
  output logic                           out_last,
  output logic                           busy,
  output logic                           err
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LASTIDX = CW'(N - 1);

  if (FBITS < 0 || FBITS > WIDTH || TIMEOUT_CYCLES < 1) begin : g_cfg_chk
    $error("softmax_stream_ctrl: bad FBITS/TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;

  logic [N-1:0][N-1:0][WIDTH-1:0] buf_in_q, buf_in_d;
  logic [N-1:0][N-1:0][WIDTH-1:0] buf_out_q, buf_out_d;

  logic start_q, start_d;
  logic adv;
  logic at_end;
  logic in_fire;
  logic out_fire;

`ifdef SOFTMAX_STREAM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          err_q, err_d;
`endif

  assign at_end   = (row_q == LASTIDX) && (col_q == LASTIDX);
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  assign in_ready  = (state_q == LOAD) && !rst;
  assign sm_start  = start_q;
  assign sm_in     = buf_in_q;
  assign out_valid = (state_q == DRAIN);
  assign out_data  = buf_out_q[row_q][col_q];
  assign out_last  = (state_q == DRAIN) && at_end;
  assign busy      = (state_q != LOAD);

`ifdef SOFTMAX_STREAM_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    buf_in_d  = buf_in_q;
    buf_out_d = buf_out_q;
    adv       = 1'b0;
`ifdef SOFTMAX_STREAM_TIMEOUT_EN
    tcnt_d    = tcnt_q;
    err_d     = err_q;
`endif

    unique case (state_q)
      LOAD: begin
        if (in_fire) begin
          buf_in_d[row_q][col_q] = in_data;
          adv = 1'b1;
          if (at_end) begin
            state_d = START;
          end
        end
      end
      START: begin
        state_d = WAIT;
`ifdef SOFTMAX_STREAM_TIMEOUT_EN
        tcnt_d  = '0;
`endif
      end
      WAIT: begin
        // done is only honoured here, never in START, so a stale level is masked
        if (sm_done) begin
          buf_out_d = sm_out;
          row_d     = '0;
          col_d     = '0;
          state_d   = DRAIN;
        end
`ifdef SOFTMAX_STREAM_TIMEOUT_EN
        else if (tcnt_q == TLAST) begin
          err_d   = 1'b1;
          row_d   = '0;
          col_d   = '0;
          state_d = LOAD;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
`endif
      end
      DRAIN: begin
        if (out_fire) begin
          adv = 1'b1;
          if (at_end) begin
            state_d = LOAD;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    if (adv) begin
      if (col_q == LASTIDX) begin
        col_d = '0;
        row_d = (row_q == LASTIDX) ? '0 : row_q + CW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    start_d = (state_d == START);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= LOAD;
      row_q     <= '0;
      col_q     <= '0;
      buf_in_q  <= '0;
      buf_out_q <= '0;
      start_q   <= 1'b0;
`ifdef SOFTMAX_STREAM_TIMEOUT_EN
      tcnt_q    <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      buf_in_q  <= buf_in_d;
      buf_out_q <= buf_out_d;
      start_q   <= start_d;
`ifdef SOFTMAX_STREAM_TIMEOUT_EN
      tcnt_q    <= tcnt_d;
      err_q     <= err_d;
`endif
    end
  end

endmodule

// File: tb/tb_softmax_stream_ctrl.sv
// tb_softmax_stream_ctrl: directed load/start/drain scenarios with a
// queue scoreboard and a behavioural mat_softmax responder (Out = In + 1).
`timescale 1ns/1ps
module tb_softmax_stream_ctrl;

  localparam int N     = 4;
  localparam int WIDTH = 32;
  localparam int FBITS = 8;
`ifdef SOFTMAX_STREAM_TIMEOUT_EN
  localparam int TOC = 20;
`else
  localparam int TOC = 4096;
`endif
  localparam int NE = N * N;
  localparam int MW = NE * WIDTH;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic sm_start;
  logic [N-1:0][N-1:0][WIDTH-1:0] sm_in;
  logic [N-1:0][N-1:0][WIDTH-1:0] sm_out;
  logic sm_done;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_data;
  logic out_last;
  logic busy;
  logic err;

  softmax_stream_ctrl #(
    .N(N), .WIDTH(WIDTH), .FBITS(FBITS), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sm_start(sm_start), .sm_in(sm_in), .sm_out(sm_out), .sm_done(sm_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int start_cnt = 0;
  int hs_cnt = 0;
  int hs_total = 0;
  int resp_mode = 0;
  int resp_delay = 5;

  logic [WIDTH:0] sb[$];
  logic [N-1:0][N-1:0][WIDTH-1:0] exp_mat;
  logic [WIDTH-1:0] mat_a[NE];
  logic [WIDTH-1:0] exp_a[NE];
  logic [WIDTH-1:0] mat_b[NE];
  logic [WIDTH-1:0] exp_b[NE];

  task automatic chk(input string nm, input logic [MW-1:0] act,
                     input logic [MW-1:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (sm_start) start_cnt++;

  // responder: models mat_softmax handshake
  initial begin : responder
    logic [N-1:0][N-1:0][WIDTH-1:0] got;
    sm_done = 1'b0;
    sm_out  = '0;
    forever begin
      @(negedge clk);
      if (sm_start && !rst) begin
        got = sm_in;
        chk("sm_in", MW'(got), MW'(exp_mat));
        repeat (resp_delay) @(posedge clk);
        #1;
        if (resp_mode != 2) begin
          for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
              sm_out[r][c] = got[r][c] + WIDTH'(1);
          sm_done = 1'b1;
          if (resp_mode == 0) begin
            @(posedge clk);
            #1;
            sm_done = 1'b0;
          end
        end
      end
    end
  end

  // monitor: pops scoreboard on every output handshake
  initial begin : monitor
    logic [WIDTH:0] e;
    logic stall_q;
    logic [WIDTH-1:0] hold_d;
    logic hold_l;
    logic exp_any;
    stall_q = 1'b0;
    hold_d  = '0;
    hold_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (stall_q) begin
          chk("bp_hold_data", MW'(out_data), MW'(hold_d));
          chk("bp_hold_last", MW'(out_last), MW'(hold_l));
        end
        if (out_ready) begin
          exp_any = (sb.size() != 0);
          chk("out_expected", MW'(out_valid), MW'(exp_any));
          if (exp_any) begin
            e = sb.pop_front();
            chk("out_data", MW'(out_data), MW'(e[WIDTH-1:0]));
            chk("out_last", MW'(out_last), MW'(e[WIDTH]));
          end
          hs_cnt = (hs_cnt + 1) % NE;
          hs_total++;
        end
        stall_q = !out_ready;
        hold_d  = out_data;
        hold_l  = out_last;
      end else begin
        if (stall_q) chk("bp_valid_held", MW'(out_valid), MW'(stall_q));
        stall_q = 1'b0;
      end
    end
  end

  task automatic feed(input logic [WIDTH-1:0] m[NE],
                      input logic [WIDTH-1:0] ex[NE],
                      input bit gaps, input bit push);
    bit ok;
    for (int i = 0; i < NE; i++) exp_mat[i / N][i % N] = m[i];
    if (push)
      for (int i = 0; i < NE; i++)
        sb.push_back({(i == NE - 1) ? 1'b1 : 1'b0, ex[i]});
    for (int i = 0; i < NE; i++) begin
      in_valid = 1'b1;
      in_data  = m[i];
      ok = 1'b0;
      for (int k = 0; k < 64 && !ok; k++) begin
        @(negedge clk);
        ok = in_ready;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b0;
      chk("in_accept", MW'(ok), MW'(1));
      if (i == NE - 1) begin
        chk("start_pulse", MW'(sm_start), MW'(1));
        chk("start_busy", MW'(busy), MW'(1));
        chk("start_in_ready", MW'(in_ready), MW'(0));
        tick;
        chk("start_one_cycle", MW'(sm_start), MW'(0));
      end else if (gaps) begin
        repeat (2) tick;
      end
    end
  endtask

  task automatic wait_drain(input string nm);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      tick;
      k++;
    end
    chk({nm, "_drained"}, MW'(sb.size()), MW'(0));
    tick;
    chk({nm, "_valid_low"}, MW'(out_valid), MW'(0));
    chk({nm, "_idle"}, MW'(busy), MW'(0));
  endtask

  initial begin : main
    int s0;
    int h0;
    bit found;
    mat_a = '{32'h40, 32'h20, 32'h10, 32'h30,
              32'h20, 32'h40, 32'h30, 32'h10,
              32'h10, 32'h30, 32'h40, 32'h20,
              32'h30, 32'h10, 32'h20, 32'h40};
    exp_a = '{32'h41, 32'h21, 32'h11, 32'h31,
              32'h21, 32'h41, 32'h31, 32'h11,
              32'h11, 32'h31, 32'h41, 32'h21,
              32'h31, 32'h11, 32'h21, 32'h41};
    mat_b = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h00000100,
              32'h00000055, 32'hFFFFFF00, 32'h00001234, 32'h0000ABCD,
              32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004,
              32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFE, 32'h00000FFF};
    exp_b = '{32'h00000000, 32'h80000000, 32'h80000001, 32'h00000101,
              32'h00000056, 32'hFFFFFF01, 32'h00001235, 32'h0000ABCE,
              32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005,
              32'hDEADBEF0, 32'h00000001, 32'hFFFFFFFF, 32'h00001000};
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    exp_mat = '0;
    repeat (2) tick;
    chk("rst_in_ready", MW'(in_ready), MW'(0));
    chk("rst_busy", MW'(busy), MW'(0));
    chk("rst_out_valid", MW'(out_valid), MW'(0));
    chk("rst_out_last", MW'(out_last), MW'(0));
    chk("rst_sm_start", MW'(sm_start), MW'(0));
    chk("rst_err", MW'(err), MW'(0));
    chk("rst_sm_in", MW'(sm_in), MW'(0));
    rst = 1'b0;
    #1;
    chk("load_in_ready", MW'(in_ready), MW'(1));

    feed(mat_a, exp_a, 1'b0, 1'b1);
    wait_drain("basic");
    chk("basic_starts", MW'(start_cnt), MW'(1));

    feed(mat_a, exp_a, 1'b1, 1'b1);
    wait_drain("gaps");
    chk("gaps_starts", MW'(start_cnt), MW'(2));

    h0 = hs_total;
    feed(mat_a, exp_a, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      tick;
      found = out_valid && (hs_cnt == 6);
    end
    chk("bp_reach_elem", MW'(found), MW'(1));
    out_ready = 1'b0;
    repeat (3) begin
      chk("bp_data_0x31", MW'(out_data), MW'(32'h31));
      tick;
    end
    out_ready = 1'b1;
    wait_drain("bp");
    chk("bp_handshakes", MW'(hs_total - h0), MW'(16));

    resp_mode = 1;
    resp_delay = 5;
    feed(mat_a, exp_a, 1'b0, 1'b1);
    wait_drain("held1");
    chk("held_done_level", MW'(sm_done), MW'(1));
    resp_delay = 1;
    feed(mat_b, exp_b, 1'b0, 1'b1);
    wait_drain("held2");
    sm_done = 1'b0;
    resp_mode = 0;
    resp_delay = 5;

    feed(mat_a, exp_a, 1'b0, 1'b0);
    tick;
    chk("rw_in_wait", MW'(busy), MW'(1));
    rst = 1'b1;
    #1;
    chk("rw_rst_in_ready", MW'(in_ready), MW'(0));
    tick;
    rst = 1'b0;
    chk("rw_busy", MW'(busy), MW'(0));
    chk("rw_out_valid", MW'(out_valid), MW'(0));
    s0 = start_cnt;
    repeat (10) tick;
    chk("rw_late_done_valid", MW'(out_valid), MW'(0));
    chk("rw_late_done_busy", MW'(busy), MW'(0));
    chk("rw_no_start", MW'(start_cnt), MW'(s0));
    feed(mat_b, exp_b, 1'b0, 1'b1);
    wait_drain("rw_clean");
    chk("rw_one_start", MW'(start_cnt - s0), MW'(1));

`ifdef SOFTMAX_STREAM_TIMEOUT_EN
    resp_mode = 2;
    feed(mat_a, exp_a, 1'b0, 1'b0);
    repeat (TOC - 1) tick;
    chk("to_err_before", MW'(err), MW'(0));
    chk("to_busy_before", MW'(busy), MW'(1));
    tick;
    chk("to_err", MW'(err), MW'(1));
    chk("to_load", MW'(busy), MW'(0));
    chk("to_in_ready", MW'(in_ready), MW'(1));
    chk("to_no_valid", MW'(out_valid), MW'(0));
    repeat (3) tick;
    chk("to_err_sticky", MW'(err), MW'(1));
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("to_err_cleared", MW'(err), MW'(0));
    resp_mode = 0;
    resp_delay = TOC;
    feed(mat_a, exp_a, 1'b0, 1'b1);
    wait_drain("to_edge");
    chk("to_edge_err", MW'(err), MW'(0));
    resp_delay = 5;
`endif

    repeat (3) tick;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
